// File: rtl/ticket_dispense_ctrl.sv
// Multi-ticket dispense controller: feeds one ticket at a time, confirms each on the
// exit sensor, retries on sensor timeout and latches a fault after repeated misses.
module ticket_dispense_ctrl #(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 1000,
  parameter int RETRIES = 2,
  parameter int GAP_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_tickets,
  input  logic             sensor_t,
  input  logic             clear_fault,
  output logic             ticket_out,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [CNT_W-1:0] issued
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RW = $clog2(RETRIES + 1);
  localparam int GW = (GAP_CYC > 2) ? $clog2(GAP_CYC - 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FEED, S_WAIT, S_GAP, S_DONE, S_FAULT
  } state_t;

  // The FEED cycle is itself one of the low gap cycles, so GAP holds GAP_CYC-1 cycles.
  localparam state_t S_REFEED = (GAP_CYC == 1) ? S_FEED : S_GAP;

  state_t           state, state_nx;
  logic [CNT_W-1:0] target, target_nx, issued_nx;
  logic [TW-1:0]    timer, timer_nx;
  logic [RW-1:0]    retry, retry_nx;
  logic [GW-1:0]    gap_cnt, gap_nx;
  logic             tout_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      target     <= '0;
      issued     <= '0;
      timer      <= '0;
      retry      <= '0;
      gap_cnt    <= '0;
      ticket_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_nx;
      target     <= target_nx;
      issued     <= issued_nx;
      timer      <= timer_nx;
      retry      <= retry_nx;
      gap_cnt    <= gap_nx;
      ticket_out <= tout_nx;
      busy       <= (state_nx != S_IDLE);
      done       <= (state_nx == S_DONE);
      fault      <= (state_nx == S_FAULT);
    end
  end

  always_comb begin
    state_nx  = state;
    target_nx = target;
    issued_nx = issued;
    timer_nx  = timer;
    retry_nx  = retry;
    gap_nx    = gap_cnt;
    tout_nx   = ticket_out;
    case (state)
      S_IDLE: begin
        if (start) begin
          issued_nx = '0;
          if (num_tickets != '0) begin
            target_nx = num_tickets;
            retry_nx  = '0;
            state_nx  = S_FEED;
          end else begin
            state_nx = S_DONE;
          end
        end
      end
      S_FEED: begin
        tout_nx  = 1'b1;
        timer_nx = '0;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (sensor_t) begin
          tout_nx   = 1'b0;
          issued_nx = issued + 1'b1;
          retry_nx  = '0;
          gap_nx    = '0;
          state_nx  = (issued_nx == target) ? S_DONE : S_REFEED;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          tout_nx  = 1'b0;
          retry_nx = retry + 1'b1;
          gap_nx   = '0;
          state_nx = (retry_nx == RW'(RETRIES)) ? S_FAULT : S_REFEED;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt == GW'(GAP_CYC - 2)) state_nx = S_FEED;
        else                             gap_nx   = gap_cnt + 1'b1;
      end
      S_DONE: state_nx = S_IDLE;
      S_FAULT: begin
        tout_nx = 1'b0;
        if (clear_fault) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ticket_dispense_ctrl.sv
// Directed bench for ticket_dispense_ctrl (TIMEOUT=8, RETRIES=2, GAP_CYC=4) with a
// sensor responder and a pulse/gap width monitor.
module tb_ticket_dispense_ctrl;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, start, sensor_t, clear_fault;
  logic [CNT_W-1:0] num_tickets;
  logic             ticket_out, busy, done, fault;
  logic [CNT_W-1:0] issued;

  ticket_dispense_ctrl #(.CNT_W(CNT_W), .TIMEOUT(8), .RETRIES(2), .GAP_CYC(4)) dut (
    .clk(clk), .rst(rst), .start(start), .num_tickets(num_tickets),
    .sensor_t(sensor_t), .clear_fault(clear_fault), .ticket_out(ticket_out),
    .busy(busy), .done(done), .fault(fault), .issued(issued)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Sensor responder: after skipping sens_skip feeds, answers up to sens_left feeds
  // with a one-cycle sensor pulse so that ticket_out stays high sens_delay cycles.
  int sens_skip = 0, sens_left = 0, sens_delay = 2;
  initial begin
    sensor_t = 1'b0;
    forever begin
      @(posedge ticket_out);
      if (sens_skip > 0) sens_skip--;
      else if (sens_left > 0) begin
        sens_left--;
        repeat (sens_delay - 1) @(posedge clk);
        #1 sensor_t = 1'b1;
        @(posedge clk);
        #1 sensor_t = 1'b0;
      end
    end
  end

  int pw[8], gw[8];
  int np = 0, ng = 0, hi_run = 0, lo_run = 0, done_cnt = 0;
  always @(negedge clk) begin
    if (ticket_out === 1'b1) begin
      if (hi_run == 0 && np > 0) begin
        if (ng < 8) gw[ng] = lo_run;
        ng++;
      end
      hi_run++;
    end else begin
      if (hi_run > 0) begin
        if (np < 8) pw[np] = hi_run;
        np++;
        hi_run = 0;
        lo_run = 0;
      end
      lo_run++;
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic clear_mon();
    np = 0; ng = 0; hi_run = 0; lo_run = 0; done_cnt = 0;
    for (int i = 0; i < 8; i++) begin pw[i] = 0; gw[i] = 0; end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int n);
    start = 1'b1;
    num_tickets = CNT_W'(n);
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 200) begin tick(1); k++; end
    check(tag, busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_tickets = '0; clear_fault = 1'b0;
    tick(2);
    check("rst_tout", ticket_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_issued", issued, 0);
    rst = 1'b0;
    tick(1);

    // 1: single ticket, sensor 3 cycles after rise
    clear_mon(); sens_skip = 0; sens_left = 1; sens_delay = 3;
    pulse_start(1);
    check("t1_lat0", ticket_out, 0);
    check("t1_busy", busy, 1);
    tick(1);
    check("t1_lat1", ticket_out, 1);
    wait_idle("t1_idle");
    check("t1_np", np, 1);
    check("t1_pw0", pw[0], 3);
    check("t1_issued", issued, 1);
    check("t1_done", done_cnt, 1);

    // 2: three tickets, gaps of exactly 4 low cycles
    clear_mon(); sens_left = 3; sens_delay = 2;
    pulse_start(3);
    wait_idle("t2_idle");
    check("t2_np", np, 3);
    check("t2_pw0", pw[0], 2);
    check("t2_pw2", pw[2], 2);
    check("t2_ng", ng, 2);
    check("t2_gw0", gw[0], 4);
    check("t2_gw1", gw[1], 4);
    check("t2_issued", issued, 3);
    check("t2_done", done_cnt, 1);

    // 3: first feed times out, retry succeeds
    clear_mon(); sens_skip = 1; sens_left = 1; sens_delay = 2;
    pulse_start(1);
    wait_idle("t3_idle");
    check("t3_np", np, 2);
    check("t3_pw0", pw[0], 8);
    check("t3_pw1", pw[1], 2);
    check("t3_gw0", gw[0], 4);
    check("t3_issued", issued, 1);
    check("t3_done", done_cnt, 1);
    check("t3_fault", fault, 0);

    // 4: sensor never answers -> fault after two timeouts
    clear_mon(); sens_skip = 0; sens_left = 0;
    pulse_start(1);
    for (int k = 0; k < 200 && fault !== 1'b1; k++) tick(1);
    check("t4_fault", fault, 1);
    tick(3);
    check("t4_fault_hold", fault, 1);
    check("t4_np", np, 2);
    check("t4_pw0", pw[0], 8);
    check("t4_pw1", pw[1], 8);
    check("t4_gw0", gw[0], 4);
    check("t4_tout", ticket_out, 0);
    check("t4_issued", issued, 0);
    check("t4_busy", busy, 1);
    check("t4_done", done_cnt, 0);
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
    check("t4_clr_busy", busy, 0);
    check("t4_clr_fault", fault, 0);

    // 5: reset during second WAIT
    clear_mon(); sens_left = 1; sens_delay = 2;
    pulse_start(2);
    for (int k = 0; k < 100 && !(np == 1 && ticket_out === 1'b1); k++) tick(1);
    check("t5_second_feed", ticket_out, 1);
    tick(2);
    #3 rst = 1'b1;
    #1;
    check("t5_async_tout", ticket_out, 0);
    check("t5_busy", busy, 0);
    check("t5_issued", issued, 0);
    check("t5_fault", fault, 0);
    tick(1);
    rst = 1'b0;
    tick(2);
    check("t5_no_done", done_cnt, 0);
    clear_mon(); sens_left = 1; sens_delay = 2;
    pulse_start(1);
    wait_idle("t5_idle");
    check("t5_re_issued", issued, 1);
    check("t5_re_done", done_cnt, 1);
    check("t5_re_pw0", pw[0], 2);

    // 6: starts while busy are dropped; num=0 gives a bare done
    clear_mon(); sens_left = 2; sens_delay = 2;
    pulse_start(2);
    tick(1);
    pulse_start(5);
    tick(2);
    pulse_start(7);
    tick(2);
    pulse_start(3);
    wait_idle("t6_idle");
    tick(2);
    check("t6_still_idle", busy, 0);
    check("t6_issued", issued, 2);
    check("t6_np", np, 2);
    check("t6_done", done_cnt, 1);
    clear_mon();
    pulse_start(0);
    check("t6_z_done", done, 1);
    check("t6_z_busy", busy, 1);
    check("t6_z_tout", ticket_out, 0);
    check("t6_z_issued", issued, 0);
    tick(1);
    check("t6_z_done_end", done, 0);
    check("t6_z_busy_end", busy, 0);
    tick(3);
    check("t6_z_np", np, 0);
    check("t6_z_done_cnt", done_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
